// File: rtl/falcon_keygen_pkg.sv
// Shared definitions for the Falcon key-generation datapath.
// Holds the sequencer state encoding, ring size, accumulator width,
// the default squared-norm bound and the small-coefficient type.
package falcon_keygen_pkg;

   localparam int LOGN_DEF       = 9;
   localparam int N              = 1 << LOGN_DEF;
   localparam int ACC_W          = 25;
   localparam int NORM_BOUND_DEF = 16823;

   typedef logic signed [7:0] coef_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN_F = 3'd1,
      ST_GAP   = 3'd2,
      ST_GEN_G = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/sq_norm_acc.sv
// Squared-norm accumulator for signed 8-bit coefficients.
// Squares the magnitude of each enabled sample and adds it to a running
// unsigned sum.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the sum (wins over enable)
//   enable     : add value^2 this cycle
//   value      : signed 8-bit coefficient
//   sum        : ACC_W-bit unsigned running sum
module sq_norm_acc
   import falcon_keygen_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic signed [7:0] value,
   output logic [ACC_W-1:0] sum
);

   logic [7:0]  mag;
   logic [14:0] sq;

   // Square the magnitude rather than the signed value so that -128 maps to
   // an unsigned 128 and squares to 16384, which fits in 15 bits.
   always_comb begin
      mag = value[7] ? 8'(-value) : 8'(value);
      sq  = 15'(mag) * 15'(mag);
   end

   // Running sum; 2N * 16384 = 2^24 is the worst case, so ACC_W = 25 never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (enable) begin
         sum <= sum + ACC_W'(sq);
      end
   end

endmodule

// File: rtl/mkgauss_fg_seq.sv
// Key-generation sequencer around one Gaussian small-polynomial sampler.
// Runs the sampler for f, pauses so the sampler reinitialises, runs it for g,
// writes every coefficient to the f/g RAMs, and accepts the pair only when
// sum(f^2)+sum(g^2) < NORM_BOUND, retrying up to MAX_TRIES times.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : run request (IDLE only), synchronous cancel
//   busy, done, norm_ok   : status; norm_ok qualifies the done pulse
//   attempts              : attempts used, held after completion
//   shk_valid/data/ready  : SHAKE256 squeeze stream
//   gs_ena, gs_rng*       : sampler enable and gated RNG pass-through
//   gs_rng_extract        : sampler consumed the current RNG word
//   gs_f_valid, gs_f      : sampler coefficient output
//   coef_we/sel/addr/data : registered coefficient RAM write port
module mkgauss_fg_seq
   import falcon_keygen_pkg::*;
#(
   parameter int LOGN       = LOGN_DEF,
   parameter int NORM_BOUND = NORM_BOUND_DEF,
   parameter int MAX_TRIES  = 255,
   parameter int GAP_CYC    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              norm_ok,
   output logic [7:0]        attempts,
   input  logic              shk_valid,
   input  logic [127:0]      shk_data,
   output logic              shk_ready,
   output logic              gs_ena,
   output logic              gs_rng_valid,
   output logic [127:0]      gs_rng,
   input  logic              gs_rng_extract,
   input  logic              gs_f_valid,
   input  logic signed [7:0] gs_f,
   output logic              coef_we,
   output logic              coef_sel,
   output logic [LOGN-1:0]   coef_addr,
   output logic signed [7:0] coef_data
);

   localparam int              NC       = 1 << LOGN;
   localparam logic [LOGN-1:0] CNT_LAST = LOGN'(NC - 1);
   localparam logic [ACC_W-1:0] BOUND   = ACC_W'(NORM_BOUND);
   localparam logic [7:0]      TRY_LIM  = 8'(MAX_TRIES);
   localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);

   state_t           state;
   state_t           state_nxt;
   logic [LOGN-1:0]  cnt;
   logic [7:0]       gap_cnt;
   logic             gap_to_g;
   logic             gap_to_g_nxt;
   logic             gen;
   logic             strobe;
   logic             acc_clear;
   logic             att_first;
   logic             att_inc;
   logic             ok_set;
   logic             ok_val;
   logic [ACC_W-1:0] acc;

   sq_norm_acc u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (acc_clear),
      .enable (strobe),
      .value  (gs_f),
      .sum    (acc)
   );

   // Next-state and control strobes. A coefficient strobe only counts while
   // generating and not being aborted; abort overrides every other transition
   // and suppresses all side effects so attempts and norm_ok are left as-is.
   always_comb begin
      state_nxt    = state;
      gap_to_g_nxt = gap_to_g;
      acc_clear    = 1'b0;
      att_first    = 1'b0;
      att_inc      = 1'b0;
      ok_set       = 1'b0;
      ok_val       = 1'b0;
      gen          = (state == ST_GEN_F) || (state == ST_GEN_G);
      strobe       = gen && gs_f_valid && !abort;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_GEN_F;
               acc_clear = 1'b1;
               att_first = 1'b1;
            end
         end
         ST_GEN_F: begin
            if (strobe && cnt == CNT_LAST) begin
               state_nxt    = ST_GAP;
               gap_to_g_nxt = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = gap_to_g ? ST_GEN_G : ST_GEN_F;
            end
         end
         ST_GEN_G: begin
            if (strobe && cnt == CNT_LAST) begin
               state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (acc < BOUND) begin
               state_nxt = ST_DONE;
               ok_set    = 1'b1;
               ok_val    = 1'b1;
            end else if (attempts == TRY_LIM) begin
               state_nxt = ST_DONE;
               ok_set    = 1'b1;
            end else begin
               state_nxt    = ST_GAP;
               gap_to_g_nxt = 1'b0;
               att_inc      = 1'b1;
               acc_clear    = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_nxt    = ST_IDLE;
         gap_to_g_nxt = gap_to_g;
         acc_clear    = 1'b0;
         att_first    = 1'b0;
         att_inc      = 1'b0;
         ok_set       = 1'b0;
      end
   end

   // State register plus the record of which polynomial follows the gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gap_to_g <= 1'b0;
      end else begin
         state    <= state_nxt;
         gap_to_g <= gap_to_g_nxt;
      end
   end

   // Coefficient index: cleared on a fresh start or a retry, otherwise it
   // advances per accepted strobe and wraps to 0 after N-1 between polynomials.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (att_first || att_inc) begin
         cnt <= '0;
      end else if (strobe) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Gap timer restarts every time the FSM is outside GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (state != ST_GAP) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // Attempt counter and verdict; both hold after completion until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         attempts <= '0;
         norm_ok  <= 1'b0;
      end else begin
         if (att_first) begin
            attempts <= 8'd1;
         end else if (att_inc) begin
            attempts <= attempts + 8'd1;
         end
         if (att_first) begin
            norm_ok <= 1'b0;
         end else if (ok_set) begin
            norm_ok <= ok_val;
         end
      end
   end

   // Registered RAM write port, one cycle behind the sampler strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_we   <= 1'b0;
         coef_sel  <= 1'b0;
         coef_addr <= '0;
         coef_data <= '0;
      end else begin
         coef_we <= strobe;
         if (strobe) begin
            coef_sel  <= (state == ST_GEN_G);
            coef_addr <= cnt;
            coef_data <= gs_f;
         end
      end
   end

   // Status and the state-gated RNG path; nothing is popped from SHAKE256
   // unless a polynomial is being generated.
   always_comb begin
      busy         = (state != ST_IDLE);
      done         = (state == ST_DONE);
      gs_ena       = gen;
      gs_rng_valid = gen && shk_valid;
      shk_ready    = gen && gs_rng_extract;
      gs_rng       = gen ? shk_data : '0;
   end

endmodule

// File: tb/tb_mkgauss_fg_seq.sv
// Self-checking bench for mkgauss_fg_seq. A behavioural sampler feeds
// coefficient patterns per attempt; a pair-level reference model predicts the
// write stream, the verdict, the attempt count and the final squared norm.
module tb_mkgauss_fg_seq;
   import falcon_keygen_pkg::*;

   localparam int LOGN = 9;
   localparam int NN   = 1 << LOGN;
   localparam int NB   = 16823;
   localparam int MT   = 3;
   localparam int GC   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              norm_ok;
   logic [7:0]        attempts;
   logic              shk_valid;
   logic [127:0]      shk_data;
   logic              shk_ready;
   logic              gs_ena;
   logic              gs_rng_valid;
   logic [127:0]      gs_rng;
   logic              gs_rng_extract;
   logic              gs_f_valid;
   logic signed [7:0] gs_f;
   logic              coef_we;
   logic              coef_sel;
   logic [LOGN-1:0]   coef_addr;
   logic signed [7:0] coef_data;

   always #5 clk = ~clk;

   mkgauss_fg_seq #(
      .LOGN       (LOGN),
      .NORM_BOUND (NB),
      .MAX_TRIES  (MT),
      .GAP_CYC    (GC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .norm_ok        (norm_ok),
      .attempts       (attempts),
      .shk_valid      (shk_valid),
      .shk_data       (shk_data),
      .shk_ready      (shk_ready),
      .gs_ena         (gs_ena),
      .gs_rng_valid   (gs_rng_valid),
      .gs_rng         (gs_rng),
      .gs_rng_extract (gs_rng_extract),
      .gs_f_valid     (gs_f_valid),
      .gs_f           (gs_f),
      .coef_we        (coef_we),
      .coef_sel       (coef_sel),
      .coef_addr      (coef_addr),
      .coef_data      (coef_data)
   );

   int check_count = 0;
   int fail_count  = 0;

   int          pat [1:3][0:2*NN-1];
   logic [17:0] exp_q[$];

   int               cyc = 0;
   int               done_count = 0;
   int               last_g_cyc = 0;
   int               last_sel = 0;
   int               last_addr = 0;
   logic             done_norm;
   logic [7:0]       done_att;
   logic [ACC_W-1:0] done_acc;
   bit               check_stream = 0;
   bit               force_extract = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      check_count++;
      if (obs !== expv) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic fill_const(input int a, input int v);
      for (int i = 0; i < 2*NN; i++) pat[a][i] = v;
   endtask

   task automatic fill_pm1(input int a);
      for (int i = 0; i < 2*NN; i++) pat[a][i] = ($urandom_range(0, 1) != 0) ? 1 : -1;
   endtask

   task automatic fill_small(input int a);
      for (int i = 0; i < 2*NN; i++) pat[a][i] = int'($urandom_range(0, 8)) - 4;
   endtask

   // Greedy decomposition of a target squared norm into a few coefficients,
   // randomly signed and scattered across f and g.
   task automatic fill_sum(input int a, input int target);
      int rem, c, k, j, t;
      for (int i = 0; i < 2*NN; i++) pat[a][i] = 0;
      rem = target;
      k = 0;
      while (rem > 0) begin
         c = 0;
         while ((c + 1) * (c + 1) <= rem && c < 127) c++;
         pat[a][k] = ($urandom_range(0, 1) != 0) ? c : -c;
         rem -= c * c;
         k++;
      end
      for (int i = 0; i < 2*NN; i++) begin
         j = int'($urandom_range(0, 2*NN - 1));
         t = pat[a][i];
         pat[a][i] = pat[a][j];
         pat[a][j] = t;
      end
   endtask

   // Pair-level reference: try each attempt's pattern until the norm passes
   // or attempts run out, recording every RAM write the block must make.
   task automatic run_model(output int e_att, output bit e_ok, output longint e_sum);
      longint s;
      exp_q.delete();
      e_att = 0;
      e_ok  = 0;
      e_sum = 0;
      for (int a = 1; a <= MT; a++) begin
         s = 0;
         for (int i = 0; i < 2*NN; i++) begin
            s += pat[a][i] * pat[a][i];
            exp_q.push_back({(i >= NN), 9'(i % NN), 8'(pat[a][i])});
         end
         e_att = a;
         e_sum = s;
         if (s < NB) begin
            e_ok = 1;
            break;
         end
      end
   endtask

   // Behavioural sampler: one coefficient per extracted word while enabled,
   // stray strobes during gaps that must be ignored, and window tracking to
   // pick the right attempt/polynomial pattern.
   initial begin
      int s_win, s_idx, a, pos;
      bit s_prev;
      s_win = 0; s_idx = 0; s_prev = 0;
      gs_rng_extract = 0; gs_f_valid = 0; gs_f = 0; shk_valid = 0; shk_data = '0;
      forever begin
         @(negedge clk);
         gs_rng_extract = 0;
         gs_f_valid     = 0;
         gs_f           = 0;
         shk_valid      = force_extract || ($urandom_range(0, 3) != 0);
         shk_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (force_extract) begin
            gs_rng_extract = 1;
         end else if (rst_n !== 1'b1 || !busy) begin
            s_win = 0; s_idx = 0; s_prev = 0;
         end else if (gs_ena) begin
            s_prev = 1;
            if (shk_valid && $urandom_range(0, 7) != 0 && s_idx < NN) begin
               a = s_win / 2 + 1;
               if (a > MT) a = MT;
               pos = (s_win % 2) * NN + s_idx;
               gs_rng_extract = 1;
               gs_f_valid     = 1;
               gs_f           = 8'(pat[a][pos]);
               s_idx++;
               #1;
               checkOutput("rng_pass", gs_rng == shk_data, 1);
               checkOutput("rng_valid", gs_rng_valid, 1);
               checkOutput("shk_ready", shk_ready, 1);
            end
         end else begin
            if (s_prev) begin
               s_win++;
               s_idx = 0;
            end
            s_prev = 0;
            if ($urandom_range(0, 1) != 0) begin
               gs_f_valid = 1;
               gs_f       = 8'sd99;
            end
         end
      end
   end

   // Monitor: write-stream scoreboard, done capture, completion latency and
   // the low time of gs_ena between sampler windows.
   initial begin
      int win, low_cnt;
      bit prev_ena, busy_pending;
      win = 0; low_cnt = 0; prev_ena = 0; busy_pending = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst_n !== 1'b1) begin
            win = 0; low_cnt = 0; prev_ena = 0; busy_pending = 0;
            continue;
         end
         if (busy_pending) begin
            checkOutput("busy_after_done", busy, 0);
            busy_pending = 0;
         end
         if (!busy) begin
            last_sel  = 0;
            last_addr = 0;
         end
         if (coef_we) begin
            last_sel  = int'(coef_sel);
            last_addr = int'(coef_addr);
            if (coef_sel) last_g_cyc = cyc;
            if (check_stream) begin
               if (exp_q.size() == 0) checkOutput("extra_write", 1, 0);
               else checkOutput("write", {coef_sel, coef_addr, coef_data}, exp_q.pop_front());
            end
         end
         if (done) begin
            done_count++;
            done_norm = norm_ok;
            done_att  = attempts;
            done_acc  = dut.u_acc.sum;
            busy_pending = 1;
            if (check_stream) checkOutput("done_latency", cyc - last_g_cyc, 1);
         end
         if (!busy) begin
            win = 0;
            low_cnt = 0;
         end else if (gs_ena) begin
            if (!prev_ena) begin
               checkOutput("ena_gap", low_cnt, (win == 0) ? 0 : ((win % 2 == 1) ? GC : GC + 1));
               win++;
            end
            low_cnt = 0;
         end else begin
            low_cnt++;
         end
         prev_ena = gs_ena;
      end
   end

   task automatic kick();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   // Full run from start to done with the current patterns, optionally
   // pulsing start again mid-run (must be ignored).
   task automatic applyStimulus(input string name, input bit inject_start);
      int     e_att, d0;
      bit     e_ok, seen;
      longint e_sum;
      run_model(e_att, e_ok, e_sum);
      check_stream = 1;
      d0 = done_count;
      @(negedge clk);
      start = 1;
      @(posedge clk);
      #1;
      checkOutput({name, "_busy_start"}, busy, 1);
      checkOutput({name, "_ena_start"}, gs_ena, 1);
      checkOutput({name, "_att_start"}, attempts, 1);
      @(negedge clk);
      start = 0;
      seen = 0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (done_count != d0) begin
            seen = 1;
            break;
         end
         start = inject_start && (k == 200 || k == 700);
      end
      start = 0;
      checkOutput({name, "_done_seen"}, seen, 1);
      if (seen) begin
         checkOutput({name, "_norm_ok"}, done_norm, e_ok);
         checkOutput({name, "_attempts"}, done_att, e_att);
         checkOutput({name, "_acc"}, done_acc, e_sum);
         checkOutput({name, "_writes_left"}, exp_q.size(), 0);
         checkOutput({name, "_done_once"}, done_count - d0, 1);
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput({name, "_att_held"}, attempts, e_att);
      checkOutput({name, "_idle"}, busy, 0);
      check_stream = 0;
      $display("[TB] %s finished", name);
   endtask

   task automatic wait_write(input int sel, input int addr, output bit ok);
      ok = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (last_sel == sel && last_addr >= addr) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int d0;
      rst_n = 0; start = 0; abort = 0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_outputs", {busy, done, norm_ok, attempts, shk_ready, gs_ena, gs_rng_valid,
                                    coef_we, coef_sel, coef_addr, coef_data}, 0);
      checkOutput("reset_rng", |gs_rng, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);

      fill_const(1, 0);
      applyStimulus("zeros", 0);

      fill_const(1, 5);
      fill_pm1(2);
      applyStimulus("over_then_pm1", 0);

      fill_sum(1, NB);
      fill_sum(2, NB - 1);
      applyStimulus("boundary", 0);

      fill_const(1, -128);
      fill_const(2, -128);
      fill_const(3, -128);
      applyStimulus("extreme", 0);

      fill_small(1);
      applyStimulus("random", 0);

      fill_small(1);
      kick();
      wait_write(1, 299, ok);
      checkOutput("abort_reach_g300", ok, 1);
      @(negedge clk);
      abort = 1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_ena", gs_ena, 0);
      checkOutput("abort_shk_ready", shk_ready, 0);
      checkOutput("abort_done", done, 0);
      @(negedge clk);
      abort = 0;
      d0 = done_count;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_no_done", done_count - d0, 0);
      checkOutput("abort_att_kept", attempts, 1);
      fill_small(1);
      applyStimulus("after_abort", 0);

      fill_small(1);
      kick();
      wait_write(0, 50, ok);
      checkOutput("reset_reach_f50", ok, 1);
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      checkOutput("midrun_reset_outputs", {busy, done, norm_ok, attempts, shk_ready, gs_ena, gs_rng_valid,
                                           coef_we, coef_sel, coef_addr, coef_data}, 0);
      checkOutput("midrun_reset_rng", |gs_rng, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      fill_small(1);
      applyStimulus("start_while_busy", 1);

      force_extract = 1;
      @(posedge clk);
      #1;
      checkOutput("idle_shk_ready", shk_ready, 0);
      checkOutput("idle_rng_valid", gs_rng_valid, 0);
      checkOutput("idle_busy", busy, 0);
      @(negedge clk);
      force_extract = 0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
